// File: rtl/inv_sbox_unit.sv
// inv_sbox_unit: sequential inverse 4-bit S-box over NIBBLES lanes, one lane
// per clock (LSB lane first), followed by a round-key XOR and a done pulse.
//
// Handshake: start is a request taken only while the unit is idle (busy=0;
// the done cycle is also idle). An accepted start captures din and key on
// that edge. busy stays high until the result is written. done pulses for
// exactly one cycle in the cycle dout changes. Starts seen while busy=1 are
// dropped, not queued.
module inv_sbox_unit #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] din,
  input  logic [W-1:0] key,
  output logic [W-1:0] dout,
  output logic         busy,
  output logic         done,
  output logic [0:0]   dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]   r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_work;
  logic [W-1:0] r_key;
  logic [W-1:0] r_dout;
  logic         r_busy;
  logic         r_done;

  logic [W-1:0] w_work_sub;
  logic         w_last;

  // Inverse substitution table for one nibble.
  function automatic logic [3:0] inv_s(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h0;  4'h1: y = 4'h8;  4'h2: y = 4'hC;  4'h3: y = 4'h2;
      4'h4: y = 4'hD;  4'h5: y = 4'h9;  4'h6: y = 4'h1;  4'h7: y = 4'h6;
      4'h8: y = 4'hE;  4'h9: y = 4'hF;  4'hA: y = 4'hB;  4'hB: y = 4'h4;
      4'hC: y = 4'h7;  4'hD: y = 4'hA;  4'hE: y = 4'h3;  default: y = 4'h5;
    endcase
    return y;
  endfunction

  // Working word with the lane selected by r_cnt substituted.
  always_comb begin
    w_work_sub = r_work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (CW'(i) == r_cnt) begin
        w_work_sub[4*i +: 4] = inv_s(r_work[4*i +: 4]);
      end
    end
    w_last = (r_cnt == CW'(NIBBLES - 1));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_key   <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_work  <= din;
            r_key   <= key;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_work_sub;
          if (w_last) begin
            // Final lane: publish the fully substituted word mixed with the key.
            r_dout  <= w_work_sub ^ r_key;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign dout      = r_dout;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule
